counter_read_responder: RTL and testbench

- Owns a free-running WIDTH-bit event counter and a snapshot shadow register.
- Serves explicit port-based read requests from a parent module: full word, single bit, or bit range. This replaces hierarchical peeks into the submodule's internal counter.
- Sits inside the submodule as the responder end of a valid/ready read interface; the parent is the initiator.

---
 rtl/counter_read_responder_if.sv | 28 ++
 rtl/counter_read_responder.sv | 117 +++++++++++
 tb/tb_counter_read_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/counter_read_responder_if.sv
// Valid/ready read channel between a parent (initiator) and the counter
// read responder living inside a submodule.
interface counter_read_responder_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_mode;
    logic             req_src;
    logic [IW-1:0]    req_lsb;
    logic [IW:0]      req_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_mode, req_src, req_lsb, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_mode, req_src, req_lsb, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/counter_read_responder.sv
// Free-running event counter with snapshot shadow, exposed to the parent
// through an explicit read channel (full word, bit select, range select)
// instead of hierarchical peeks.
module counter_read_responder #(
    parameter int WIDTH = 8,
    parameter int INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic cnt_clr,
    input  logic snap_capture,
    output logic wrap_flag,
    counter_read_responder_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic {IDLE, RESP} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] counter, snapshot;
    logic [WIDTH:0]   sum;
    logic             accept;

    // Response computed from the pre-edge source value of the current request
    logic [WIDTH-1:0] src, shifted, range_mask, calc_data;
    logic [IW+1:0]    lsb_ext, len_ext, end_ext;
    logic             calc_err;

    // Carry out of the adder is the wrap indication
    assign sum    = {1'b0, counter} + {1'b0, INC_W};
    assign accept = bus.req_valid && bus.req_ready;

    // Counter and sticky wrap flag; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            wrap_flag <= 1'b0;
        end else if (cnt_clr) begin
            counter   <= '0;
            wrap_flag <= 1'b0;
        end else if (cnt_en) begin
            counter <= sum[WIDTH-1:0];
            if (sum[WIDTH]) wrap_flag <= 1'b1;
        end
    end

    // Snapshot takes the value the counter holds before this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               snapshot <= '0;
        else if (snap_capture) snapshot <= counter;
    end

    // Decode the request into response data / error
    always_comb begin
        src        = bus.req_src ? snapshot : counter;
        lsb_ext    = (IW+2)'(bus.req_lsb);
        len_ext    = (IW+2)'(bus.req_len);
        end_ext    = lsb_ext + len_ext;
        shifted    = src >> bus.req_lsb;
        // Shifting all-ones past WIDTH leaves zero, so len >= WIDTH keeps every bit
        range_mask = ~({WIDTH{1'b1}} << bus.req_len);
        calc_data  = '0;
        calc_err   = 1'b0;
        case (bus.req_mode)
            2'b00: calc_data = src;
            2'b01: begin
                if (lsb_ext >= (IW+2)'(WIDTH)) calc_err = 1'b1;
                else calc_data = {{(WIDTH-1){1'b0}}, shifted[0]};
            end
            2'b10: begin
                if (len_ext == '0 || end_ext > (IW+2)'(WIDTH)) calc_err = 1'b1;
                else calc_data = shifted & range_mask;
            end
            default: calc_err = 1'b1;
        endcase
    end

    // Response registers update only on accept so they hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else if (accept) begin
            bus.rsp_data <= calc_data;
            bus.rsp_err  <= calc_err;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state and handshake outputs; a response handshake frees the slot
    // in the same cycle so back-to-back requests see no bubble
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) next_state = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.req_ready = bus.rsp_ready;
                if (accept)             next_state = RESP;
                else if (bus.rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_counter_read_responder.sv
// Directed bench for counter_read_responder (WIDTH=8, INC=1).
module tb_counter_read_responder;
    logic clk = 1'b0;
    logic rst;
    logic cnt_en, cnt_clr, snap_capture;
    logic wrap_flag;
    int   n_cmp = 0;
    int   n_err = 0;

    counter_read_responder_if #(.WIDTH(8)) bus ();

    counter_read_responder #(.WIDTH(8), .INC(1)) dut (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .snap_capture(snap_capture), .wrap_flag(wrap_flag), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, check the held response, then consume it
    task automatic read(input string tag, input logic [1:0] mode, input logic src,
                        input logic [2:0] lsb, input logic [3:0] len,
                        input logic [7:0] exp_data, input logic exp_err);
        bus.req_valid = 1'b1; bus.req_mode = mode; bus.req_src = src;
        bus.req_lsb = lsb; bus.req_len = len; bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cnt_en = 0; cnt_clr = 0; snap_capture = 0;
        bus.req_valid = 0; bus.req_mode = 0; bus.req_src = 0;
        bus.req_lsb = 0; bus.req_len = 0; bus.rsp_ready = 0;
        repeat (2) tick();
        chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
        chk("rst_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_wrap", 32'(wrap_flag), 32'd0);
        rst = 1'b0;

        // Reset in the middle of an unconsumed response
        cnt_en = 1; repeat (3) tick(); cnt_en = 0;
        bus.req_valid = 1; bus.req_mode = 2'b00; bus.req_src = 0;
        tick();
        bus.req_valid = 0;
        chk("pre_rst_data", 32'(bus.rsp_data), 32'h03);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vld", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_data", 32'(bus.rsp_data), 32'd0);
        chk("async_rst_wrap", 32'(wrap_flag), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        read("post_rst_cnt", 2'b00, 0, 0, 0, 8'h00, 0);

        // Count 5, then read with cnt_en still active in the accept cycle
        cnt_en = 1; repeat (5) tick();
        bus.req_valid = 1; bus.req_mode = 2'b00; bus.req_src = 0; bus.rsp_ready = 0;
        tick();
        bus.req_valid = 0; cnt_en = 0;
        chk("cnt5_data", 32'(bus.rsp_data), 32'h05);
        bus.rsp_ready = 1; tick(); bus.rsp_ready = 0;
        read("cnt6", 2'b00, 0, 0, 0, 8'h06, 0);

        // Bring the counter to A5 and exercise selects
        cnt_clr = 1; tick(); cnt_clr = 0;
        cnt_en = 1; repeat (165) tick(); cnt_en = 0;
        read("a5_full", 2'b00, 0, 0, 0, 8'hA5, 0);
        read("bit7", 2'b01, 0, 3'd7, 0, 8'h01, 0);
        read("bit1", 2'b01, 0, 3'd1, 0, 8'h00, 0);
        read("rng0_4", 2'b10, 0, 3'd0, 4'd4, 8'h05, 0);
        read("rng4_4", 2'b10, 0, 3'd4, 4'd4, 8'h0A, 0);
        read("rng2_6", 2'b10, 0, 3'd2, 4'd6, 8'h29, 0);
        read("rng0_8", 2'b10, 0, 3'd0, 4'd8, 8'hA5, 0);
        read("rng2_8_err", 2'b10, 0, 3'd2, 4'd8, 8'h00, 1);
        read("rng1_0_err", 2'b10, 0, 3'd1, 4'd0, 8'h00, 1);
        read("mode3_err", 2'b11, 0, 0, 0, 8'h00, 1);

        // Backpressure then back-to-back request
        bus.req_valid = 1; bus.req_mode = 2'b00; bus.req_src = 0; bus.rsp_ready = 0;
        tick();
        bus.req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_vld", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data", 32'(bus.rsp_data), 32'hA5);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1; bus.req_valid = 1; bus.req_mode = 2'b01; bus.req_lsb = 3'd0;
        #1;
        chk("b2b_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 0;
        chk("b2b_vld", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_data", 32'(bus.rsp_data), 32'h01);
        tick();
        chk("b2b_done", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 0;

        // Wrap from FF, then clear colliding with enable
        cnt_en = 1; repeat (90) tick(); cnt_en = 0;
        read("ff_full", 2'b00, 0, 0, 0, 8'hFF, 0);
        chk("pre_wrap", 32'(wrap_flag), 32'd0);
        cnt_en = 1; tick(); cnt_en = 0;
        chk("wrap_set", 32'(wrap_flag), 32'd1);
        read("wrap_cnt", 2'b00, 0, 0, 0, 8'h00, 0);
        cnt_en = 1; repeat (3) tick();
        cnt_clr = 1; tick(); cnt_clr = 0; cnt_en = 0;
        chk("clr_wrap", 32'(wrap_flag), 32'd0);
        read("clr_cnt", 2'b00, 0, 0, 0, 8'h00, 0);

        // Snapshot: 10 captured, counter at 33, capture during accept
        cnt_en = 1; repeat (16) tick();
        snap_capture = 1; tick(); snap_capture = 0;
        repeat (34) tick(); cnt_en = 0;
        read("live33", 2'b00, 0, 0, 0, 8'h33, 0);
        snap_capture = 1;
        bus.req_valid = 1; bus.req_mode = 2'b00; bus.req_src = 1; bus.rsp_ready = 0;
        tick();
        snap_capture = 0; bus.req_valid = 0;
        chk("snap_old", 32'(bus.rsp_data), 32'h10);
        bus.rsp_ready = 1; tick(); bus.rsp_ready = 0;
        read("snap_new", 2'b00, 1, 0, 0, 8'h33, 0);
        read("snap_rng", 2'b10, 1, 3'd4, 4'd2, 8'h03, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
